// File: rtl/pgm_mem_loader_pkg.sv
// Shared types for the program-memory loader: serialiser states, FIFO entry
// layout and the endian-aware byte picker.
package pgm_mem_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_BYTE0,
      S_BYTE1,
      S_BYTE2,
      S_BYTE3
   } ser_state_t;

   // Offset is the word index inside the window, zero-extended to the widest case.
   typedef struct packed {
      logic [29:0] offset;
      logic [31:0] data;
      logic        little;
   } fifo_entry_t;

   function automatic logic [7:0] byte_select(input logic [31:0] data,
                                              input logic [1:0]  idx,
                                              input logic        little);
      logic [1:0] lane;
      lane = little ? idx : (2'd3 - idx);
      return data[8*lane +: 8];
   endfunction

endpackage

// File: rtl/pgm_mem_loader_if.sv
// Bridge write bus feeding the loader.
interface pgm_mem_loader_if;
   logic        bridge_endian_little;
   logic [31:0] bridge_addr;
   logic        bridge_wr;
   logic [31:0] bridge_wr_data;

   modport master (output bridge_endian_little, bridge_addr, bridge_wr, bridge_wr_data);
   modport slave  (input  bridge_endian_little, bridge_addr, bridge_wr, bridge_wr_data);
endinterface

// File: rtl/pgm_mem_loader_ram.sv
// Simple dual-port program RAM: one byte-wide array per lane so each lane has
// its own write enable; registered read, read-before-write on collisions.
module pgm_ram #(
   parameter int DEPTH_WORDS = 16384,
   parameter int WORD_BYTES  = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [WORD_BYTES-1:0]          we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] wr_addr,
   input  logic [8*WORD_BYTES-1:0]        wr_data,
   input  logic [$clog2(DEPTH_WORDS)-1:0] rd_addr,
   output logic [8*WORD_BYTES-1:0]        rd_data
);

   genvar gi;
   generate
      for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
         logic [7:0] mem [DEPTH_WORDS];
         logic [7:0] rd_lane_reg;

         always_ff @(posedge clk) begin
            if (we[gi]) begin
               mem[wr_addr] <= wr_data[8*gi +: 8];
            end
            if (rst) begin
               rd_lane_reg <= '0;
            end else begin
               rd_lane_reg <= mem[rd_addr];
            end
         end

         assign rd_data[8*gi +: 8] = rd_lane_reg;
      end
   endgenerate

endmodule

// File: rtl/pgm_mem_loader.sv
// Program-memory loader: windowed bridge writes -> FIFO -> byte serialiser ->
// byte-lane RAM, with progress counters, checksum and sticky error flags.
module pgm_mem_loader
   import pgm_mem_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WIN_BITS    = 24,
   parameter int          DEPTH_WORDS = 16384,
   parameter int          WORD_BYTES  = 2,
   parameter int          FIFO_DEPTH  = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   pgm_mem_loader_if.slave                bridge,
   input  logic                           clear,
   input  logic [$clog2(DEPTH_WORDS)-1:0] rd_addr,
   output logic [8*WORD_BYTES-1:0]        rd_data,
   output logic [31:0]                    byte_count,
   output logic [7:0]                     checksum,
   output logic                           load_active,
   output logic                           overflow,
   output logic                           range_err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LANE_SHIFT = $clog2(WORD_BYTES);
   localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) * 33'(WORD_BYTES);
   localparam logic [WORD_BYTES-1:0] LANE0 = 1;

   fifo_entry_t            fifo_mem [FIFO_DEPTH];
   logic [PW:0]            wr_ptr_reg, rd_ptr_reg;
   logic                   fifo_empty, fifo_full, win_hit, push, pop;
   fifo_entry_t            push_entry;

   ser_state_t             state_reg;
   fifo_entry_t            cur_reg;
   logic [31:0]            byte_count_reg;
   logic [7:0]             checksum_reg;
   logic                   overflow_reg, range_err_reg;

   logic [1:0]             byte_idx, lane_sel;
   logic                   byte_active, in_range;
   logic [32:0]            byte_addr;
   logic [7:0]             cur_byte;
   logic [WORD_BYTES-1:0]  lane_we;
   logic [AW-1:0]          word_addr;

   assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
   assign fifo_full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                       (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);

   // BASE_ADDR is window-aligned, so the window offset is simply the low address bits.
   assign win_hit           = (bridge.bridge_addr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
   assign push_entry.offset = 30'(bridge.bridge_addr[WIN_BITS-1:2]);
   assign push_entry.data   = bridge.bridge_wr_data;
   assign push_entry.little = bridge.bridge_endian_little;

   // Full is judged before any pop this cycle, so push-on-full is dropped even when a pop frees a slot.
   assign push = bridge.bridge_wr && win_hit && !fifo_full && !clear;
   assign pop  = !fifo_empty && ((state_reg == S_IDLE) || (state_reg == S_BYTE3));

   always_comb begin
      byte_idx    = 2'd0;
      byte_active = 1'b1;
      case (state_reg)
         S_BYTE0: byte_idx = 2'd0;
         S_BYTE1: byte_idx = 2'd1;
         S_BYTE2: byte_idx = 2'd2;
         S_BYTE3: byte_idx = 2'd3;
         default: byte_active = 1'b0;
      endcase
      byte_addr = {1'b0, cur_reg.offset, byte_idx};
      in_range  = (byte_addr < MEM_BYTES);
      cur_byte  = byte_select(cur_reg.data, byte_idx, cur_reg.little);
      word_addr = AW'(byte_addr >> LANE_SHIFT);
      lane_sel  = byte_addr[1:0] & 2'(WORD_BYTES - 1);
      lane_we   = '0;
      if (byte_active && in_range && !clear && !rst) begin
         lane_we = LANE0 << lane_sel;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst) begin
         fifo_mem[wr_ptr_reg[PW-1:0]] <= push_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         state_reg      <= S_IDLE;
         cur_reg        <= '0;
         byte_count_reg <= '0;
         checksum_reg   <= '0;
         overflow_reg   <= 1'b0;
         range_err_reg  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (bridge.bridge_wr && win_hit && fifo_full) begin
            overflow_reg <= 1'b1;
         end
         if (byte_active) begin
            if (in_range) begin
               byte_count_reg <= byte_count_reg + 32'd1;
               checksum_reg   <= checksum_reg + cur_byte;
            end else begin
               range_err_reg <= 1'b1;
            end
         end
         if (pop) begin
            cur_reg    <= fifo_mem[rd_ptr_reg[PW-1:0]];
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case (state_reg)
            S_IDLE:  if (pop) state_reg <= S_BYTE0;
            S_BYTE0: state_reg <= S_BYTE1;
            S_BYTE1: state_reg <= S_BYTE2;
            S_BYTE2: state_reg <= S_BYTE3;
            S_BYTE3: state_reg <= pop ? S_BYTE0 : S_IDLE;
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   pgm_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .WORD_BYTES  (WORD_BYTES)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we      (lane_we),
      .wr_addr (word_addr),
      .wr_data ({WORD_BYTES{cur_byte}}),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   assign byte_count  = byte_count_reg;
   assign checksum    = checksum_reg;
   assign overflow    = overflow_reg;
   assign range_err   = range_err_reg;
   assign load_active = !fifo_empty || (state_reg != S_IDLE);

endmodule
